// File: rtl/i_branch_unit.sv
// Conditional branch resolver: compares two operands per the opcode and registers
// either the PC-relative branch target or the fall-through PC with a taken flag.
module i_branch_unit #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_reg,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] reg_1,
  input  logic [DATA_W-1:0] reg_2,
  output logic [PC_W-1:0]   new_PC,
  output logic              taken
);

  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_BGT  = 6'b010010;
  localparam logic [5:0] OP_BGTE = 6'b010011;
  localparam logic [5:0] OP_BLT  = 6'b010100;
  localparam logic [5:0] OP_BLTE = 6'b010101;
  localparam logic [5:0] OP_BGTU = 6'b010110;
  localparam logic [5:0] OP_BLTU = 6'b010111;

  logic [5:0]      w_opcode;
  logic [15:0]     w_imm;
  logic [PC_W-1:0] w_immExt;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pcPlusOne;
  logic            w_taken;
  logic            w_unused;

  assign w_opcode = inst_reg[31:26];
  assign w_imm    = inst_reg[15:0];
  // Register numbers in [25:16] are redundant because operand values arrive directly.
  assign w_unused = ^inst_reg[25:16];

  // Only the low PC_W bits of the sum matter, so sign-extend (or truncate) imm to PC_W.
  assign w_immExt    = PC_W'($signed(w_imm));
  assign w_target    = PC + w_immExt;
  assign w_pcPlusOne = PC + PC_W'(1);

  always_comb begin
    w_taken = 1'b0;
    case (w_opcode)
      OP_BEQ:  w_taken = (reg_1 == reg_2);
      OP_BNE:  w_taken = (reg_1 != reg_2);
      OP_BGT:  w_taken = ($signed(reg_1) >  $signed(reg_2));
      OP_BGTE: w_taken = ($signed(reg_1) >= $signed(reg_2));
      OP_BLT:  w_taken = ($signed(reg_1) <  $signed(reg_2));
      OP_BLTE: w_taken = ($signed(reg_1) <= $signed(reg_2));
      OP_BGTU: w_taken = (reg_1 >  reg_2);
      OP_BLTU: w_taken = (reg_1 <  reg_2);
      default: w_taken = 1'b0;
    endcase
  end

  logic [PC_W-1:0] r_newPc;
  logic            r_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_newPc <= '0;
      r_taken <= 1'b0;
    end else begin
      r_newPc <= w_taken ? w_target : w_pcPlusOne;
      r_taken <= w_taken;
    end
  end

  assign new_PC = r_newPc;
  assign taken  = r_taken;

endmodule

// File: tb/tb_i_branch_unit.sv
// Directed bench for i_branch_unit: each vector is applied, one edge taken, and the
// registered next-PC and taken flag compared against hand-computed values.
module tb_i_branch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instReg;
  logic [8:0]  pc;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [8:0]  newPc;
  logic        taken;

  int checkCount = 0;
  int errorCount = 0;

  i_branch_unit #(.PC_W(9), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_reg (instReg),
    .PC       (pc),
    .reg_1    (reg1),
    .reg_2    (reg2),
    .new_PC   (newPc),
    .taken    (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one vector, let it be registered on the next edge, then sample away from it.
  task automatic applyStimulus(input string tag, input logic r, input logic [31:0] inst,
                               input logic [8:0] p, input logic [31:0] a,
                               input logic [31:0] b, input logic [8:0] expPc,
                               input logic expTaken);
    rst     = r;
    instReg = inst;
    pc      = p;
    reg1    = a;
    reg2    = b;
    @(posedge clk);
    #1;
    checkOutput({tag, ".new_PC"}, 32'(newPc), 32'(expPc));
    checkOutput({tag, ".taken"},  32'(taken), 32'(expTaken));
  endtask

  initial begin
    rst = 1'b1; instReg = '0; pc = '0; reg1 = '0; reg2 = '0;
    @(posedge clk);
    #1;

    applyStimulus("reset_with_taken_beq", 1'b1, 32'h4000_0003, 9'd1, 32'd7, 32'd7, 9'd0, 1'b0);
    applyStimulus("beq_not_taken",        1'b0, 32'h4000_0003, 9'd1, 32'd1, 32'd2, 9'd2, 1'b0);
    applyStimulus("bne_not_taken",        1'b0, 32'h4400_0002, 9'd1, 32'd1, 32'd1, 9'd2, 1'b0);
    applyStimulus("bne_taken",            1'b0, 32'h4400_0002, 9'd1, 32'd1, 32'd5, 9'd3, 1'b1);
    applyStimulus("beq_taken",            1'b0, 32'h4000_0003, 9'd1, 32'd7, 32'd7, 9'd4, 1'b1);
    applyStimulus("blt_signed",           1'b0, 32'h5000_0005, 9'd10, 32'hFFFF_FFFF, 32'd1, 9'd15, 1'b1);
    applyStimulus("bltu_unsigned",        1'b0, 32'h5C00_0005, 9'd10, 32'hFFFF_FFFF, 32'd1, 9'd11, 1'b0);
    applyStimulus("nonbranch_wrap",       1'b0, 32'h0000_0000, 9'd511, 32'd0, 32'd0, 9'd0, 1'b0);
    applyStimulus("neg_imm_wrap",         1'b0, 32'h4000_FFFE, 9'd1, 32'd9, 32'd9, 9'd511, 1'b1);
    applyStimulus("bgt_signed",           1'b0, 32'h4800_0004, 9'd20, 32'd5, 32'hFFFF_FFFD, 9'd24, 1'b1);
    applyStimulus("bgtu_unsigned",        1'b0, 32'h5800_0004, 9'd20, 32'd5, 32'hFFFF_FFFD, 9'd21, 1'b0);
    applyStimulus("bgte_equal",           1'b0, 32'h4C00_0002, 9'd20, 32'd6, 32'd6, 9'd22, 1'b1);
    applyStimulus("blte_greater",         1'b0, 32'h5400_0002, 9'd20, 32'd3, 32'd2, 9'd21, 1'b0);
    applyStimulus("blte_negative",        1'b0, 32'h5400_0002, 9'd20, 32'h8000_0000, 32'd2, 9'd22, 1'b1);
    applyStimulus("bad_opcode",           1'b0, 32'h6000_0002, 9'd5, 32'd4, 32'd4, 9'd6, 1'b0);
    applyStimulus("imm_upper_bits",       1'b0, 32'h4000_0203, 9'd1, 32'd8, 32'd8, 9'd4, 1'b1);
    applyStimulus("ignored_fields",       1'b0, 32'h43FF_0003, 9'd1, 32'd8, 32'd8, 9'd4, 1'b1);
    applyStimulus("midseq_reset",         1'b1, 32'h4000_0003, 9'd100, 32'd8, 32'd8, 9'd0, 1'b0);
    applyStimulus("after_reset",          1'b0, 32'h4000_0003, 9'd100, 32'd8, 32'd8, 9'd103, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/i_branch_unit.md
I_BRANCH_UNIT -- requirements
Module: I_Branch

Interface
REQ-001 The module SHALL have parameter PC_W, default 9, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning register-operand and instruction width in bits.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: inst_reg  input  DATA_W  current instruction word.
REQ-007 Port: PC  input  PC_W  address of the current instruction.
REQ-008 Port: reg_1  input  DATA_W  first source operand (rs value).
REQ-009 Port: reg_2  input  DATA_W  second source operand (rt value).
REQ-010 Port: new_PC  output  PC_W  registered next-PC.
REQ-011 Port: taken  output  1  registered flag, 1 when the branch redirected the PC.

Function
REQ-012 Instruction fields SHALL be: opcode = inst_reg[31:26], imm = inst_reg[15:0]; bits [25:16] are ignored, because operands arrive on reg_1/reg_2.
REQ-013 Opcode decode SHALL be:
- 010000 BEQ: reg_1 == reg_2
- 010001 BNE: reg_1 != reg_2
- 010010 BGT: signed reg_1 > reg_2
- 010011 BGTE: signed reg_1 >= reg_2
- 010100 BLT: signed reg_1 < reg_2
- 010101 BLTE: signed reg_1 <= reg_2
- 010110 BGTU: unsigned reg_1 > reg_2
- 010111 BLTU: unsigned reg_1 < reg_2
REQ-014 Signed compares SHALL treat reg_1 and reg_2 as DATA_W-bit two's complement; unsigned compares SHALL treat them as unsigned.
REQ-015 Any opcode outside 010000..010111 SHALL be not-taken.
REQ-016 On a taken branch, the target SHALL be (PC + sign-extended imm) modulo 2^PC_W, using only the low PC_W bits of the sum.
REQ-017 On a not-taken branch, the next PC SHALL be (PC + 1) modulo 2^PC_W; PC = 511 gives 0.
REQ-018 Compare, target and PC+1 logic SHALL be combinational from the current inputs.
REQ-019 new_PC and taken SHALL be registered on the rising edge of clk, giving 1-cycle latency: inputs present before edge N appear on the outputs after edge N.
REQ-020 The outputs SHALL update on every clock edge; there is no enable and no handshake.
REQ-021 A negative imm SHALL wrap below 0 modulo 2^PC_W; PC = 1 with imm = 0xFFFE (-2) gives 511.
REQ-022 Upper imm bits beyond PC_W SHALL affect the result only through the modulo sum.

Reset
REQ-023 When rst = 1 at a rising clk edge, new_PC SHALL become 0 and taken SHALL become 0, regardless of the other inputs.
REQ-024 rst SHALL take priority over a simultaneous branch evaluation.
REQ-025 The first edge with rst = 0 SHALL register a normal evaluation of the inputs present at that edge.
REQ-026 rst asserted mid-sequence SHALL discard the pending result, with no carry-over of the previous value.

Verification
REQ-027 BEQ (0x40000003), PC = 1, reg_1 = 1, reg_2 = 2 -> after the edge, new_PC = 2, taken = 0.
REQ-028 BNE (0x44000002), PC = 1, reg_1 = 1, reg_2 = 1 -> new_PC = 2, taken = 0; the same instruction with reg_2 = 5 -> new_PC = 3, taken = 1.
REQ-029 BEQ with imm = 3, PC = 1, reg_1 = reg_2 = 7 -> new_PC = 4, taken = 1.
REQ-030 BLT versus BLTU with reg_1 = 0xFFFFFFFF, reg_2 = 1, PC = 10, imm = 5:
- BLT -> new_PC = 15, taken = 1 (signed -1 < 1)
- BLTU -> new_PC = 11, taken = 0
REQ-031 Wrap cases:
- PC = 511, non-branch opcode 000000 -> new_PC = 0, taken = 0
- PC = 1, BEQ taken, imm = 0xFFFE -> new_PC = 511
REQ-032 Assert rst alongside a taken BEQ -> new_PC = 0, taken = 0; deassert rst -> the next edge gives the normal result.
